// File: rtl/jtag_er_ctrl_if.sv
// jtag_er_ctrl_if: fabric-side command/response bus of the JTAG ER1/ER2 controller.
// master = controller side, slave = fabric side.
interface jtag_er_ctrl_if #(parameter int DR_W = 8);
   logic [DR_W-1:0] cmd_data;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_chan;
   logic [DR_W-1:0] rsp_data;
   logic            rsp_valid;
   logic            ovr_err;
   logic            len_err;
   modport master (output cmd_data, cmd_valid, cmd_chan, ovr_err, len_err,
                   input  cmd_ready, rsp_data, rsp_valid);
   modport slave  (input  cmd_data, cmd_valid, cmd_chan, ovr_err, len_err,
                   output cmd_ready, rsp_data, rsp_valid);
endinterface

// File: rtl/jtag_er_ctrl.sv
// jtag_er_ctrl: JTAGG ER1/ER2 user data register controller with a command/response handshake.
// Optional macro JTAG_ER2_STATUS_EN turns ER2 into a status/clear channel.
module jtag_er_ctrl #(parameter int DR_W = 8) (
   input  logic           jtck,
   input  logic           jrstn,
   input  logic           jtdi,
   input  logic           jshift,
   input  logic           jupdate,
   input  logic           jce1,
   input  logic           jce2,
   output logic           jtdo1,
   output logic           jtdo2,
   jtag_er_ctrl_if.master bus
);
   localparam int CW = $clog2(DR_W + 2);
   typedef enum logic [1:0] {IDLE, CAPT, SHIFT, EXIT} state_t;
   state_t          state_q, state_d;
   logic [DR_W-1:0] sr_q, sr_d, rsp_q, rsp_d, cmd_data_q, cmd_data_d, cap;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cmd_valid_q, cmd_valid_d, cmd_chan_q, cmd_chan_d, act_q, act_d;
   logic            dly_q, dly_d, ovr_q, ovr_d, len_q, len_d;
   logic            rise, len_ok, tdo;
   always_comb begin
      rise        = jshift && !dly_q;
      len_ok      = cnt_q == CW'(DR_W);
`ifdef JTAG_ER2_STATUS_EN
      cap         = jce1 ? rsp_q : DR_W'({ovr_q, len_q, cmd_valid_q});
`else
      cap         = rsp_q;
`endif
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      act_d       = act_q;
      cmd_data_d  = cmd_data_q;
      cmd_chan_d  = cmd_chan_q;
      ovr_d       = ovr_q;
      len_d       = len_q;
      dly_d       = jshift;
      rsp_d       = bus.rsp_valid ? bus.rsp_data : rsp_q;
      cmd_valid_d = cmd_valid_q && !bus.cmd_ready;
      tdo         = 1'b0;
      case (state_q)
         IDLE, EXIT: begin
            if (state_q == EXIT && jupdate) begin
               state_d = IDLE;
`ifdef JTAG_ER2_STATUS_EN
               if (act_q) begin
                  if (!len_ok) len_d = 1'b1;
                  else if (sr_q[0]) begin
                     ovr_d = 1'b0;
                     len_d = 1'b0;
                  end
               end else
`endif
               begin
                  // an accept in this same cycle still counts as an overrun
                  if (!len_ok) len_d = 1'b1;
                  if (cmd_valid_q) ovr_d = 1'b1;
                  if (len_ok && !cmd_valid_q) begin
                     cmd_data_d  = sr_q;
                     cmd_chan_d  = act_q;
                     cmd_valid_d = 1'b1;
                  end
               end
            end else if (jce1 || jce2) begin
               state_d = CAPT;
               sr_d    = cap;
               act_d   = !jce1;
               cnt_d   = '0;
            end else if (state_q == EXIT && rise) begin
               state_d = SHIFT;
               tdo     = sr_q[0];
            end
         end
         CAPT: begin
            // JTDI lags JSHIFT, so the entry cycle only presents bit 0
            if (rise) begin
               state_d = SHIFT;
               tdo     = sr_q[0];
            end
         end
         SHIFT: begin
            tdo   = sr_q[1];
            sr_d  = {jtdi, sr_q[DR_W-1:1]};
            cnt_d = cnt_q == CW'(DR_W + 1) ? cnt_q : cnt_q + 1'b1;
            if (!jshift) state_d = EXIT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge jtck or negedge jrstn) begin
      if (!jrstn) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         rsp_q       <= '0;
         cmd_data_q  <= '0;
         cmd_valid_q <= 1'b0;
         cmd_chan_q  <= 1'b0;
         act_q       <= 1'b0;
         cnt_q       <= '0;
         dly_q       <= 1'b0;
         ovr_q       <= 1'b0;
         len_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         rsp_q       <= rsp_d;
         cmd_data_q  <= cmd_data_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_chan_q  <= cmd_chan_d;
         act_q       <= act_d;
         cnt_q       <= cnt_d;
         dly_q       <= dly_d;
         ovr_q       <= ovr_d;
         len_q       <= len_d;
      end
   end
   assign jtdo1         = tdo && !act_q;
   assign jtdo2         = tdo && act_q;
   assign bus.cmd_data  = cmd_data_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_chan  = cmd_chan_q;
   assign bus.ovr_err   = ovr_q;
   assign bus.len_err   = len_q;
endmodule

// File: tb/tb_jtag_er_ctrl.sv
// tb_jtag_er_ctrl: scoreboard bench for jtag_er_ctrl (TDO bits and command words).
module tb_jtag_er_ctrl;
   localparam int DR_W = 8;
   logic jtck = 0, jrstn = 0, jtdi = 0, jshift = 0, jupdate = 0, jce1 = 0, jce2 = 0;
   logic jtdo1, jtdo2;
   int   total = 0, bad = 0;
   typedef struct {logic [7:0] d; logic c;} cmd_t;
   cmd_t cmd_q[$];
   logic tdo_q[$];
   jtag_er_ctrl_if #(.DR_W(DR_W)) bus();
   jtag_er_ctrl #(.DR_W(DR_W)) dut (
      .jtck(jtck), .jrstn(jrstn), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
      .jce1(jce1), .jce2(jce2), .jtdo1(jtdo1), .jtdo2(jtdo2), .bus(bus.master));
   always #5 jtck = ~jtck;
   task automatic step;
      @(posedge jtck);
      #1;
   endtask
   task automatic load_rsp(input logic [7:0] v);
      bus.rsp_valid = 1;
      bus.rsp_data  = v;
      step;
      bus.rsp_valid = 0;
   endtask
   task automatic scan(input logic ch, input logic [7:0] din, input int n, input logic [7:0] cap,
                       input bit chk, input int rst_at, input bit rv, input logic [7:0] rd);
      logic e, a;
      if (chk) for (int i = 0; i < 8; i++) tdo_q.push_back(cap[i]);
      jce1 = !ch; jce2 = ch; bus.rsp_valid = rv; bus.rsp_data = rd;
      step;
      jce1 = 0; jce2 = 0; bus.rsp_valid = 0;
      step;
      for (int i = 0; i < n; i++) begin
         jshift = 1;
         jtdi   = (i == 0) ? 1'b0 : din[i-1];
         if (i == rst_at) begin
            jrstn = 0;
            #1;
            total++;
            if ({jtdo1, jtdo2, bus.cmd_valid, bus.cmd_data, bus.ovr_err, bus.len_err} !== '0) begin
               bad++;
               $display("FAIL reset_mid outputs: got tdo=%b%b v=%b d=%h o=%b l=%b want all 0",
                        jtdo1, jtdo2, bus.cmd_valid, bus.cmd_data, bus.ovr_err, bus.len_err);
            end
            jshift = 0; jtdi = 0;
            step;
            jrstn = 1;
            step;
            return;
         end
         #1;
         if (chk && i < 8) begin
            e = tdo_q.pop_front();
            a = ch ? jtdo2 : jtdo1;
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL tdo bit %0d ch%0d: got %b want %b", i, ch, a, e);
            end
         end
         total++;
         if ((ch ? jtdo1 : jtdo2) !== 1'b0) begin
            bad++;
            $display("FAIL idle tdo bit %0d ch%0d: got 1 want 0", i, !ch);
         end
         step;
      end
      jshift = 0; jtdi = din[n-1];
      step;
      jtdi = 0;
      step;
      jupdate = 1;
      step;
      jupdate = 0;
      step;
   endtask
   task automatic drain;
      int   w = 0;
      cmd_t c;
      while (!bus.cmd_valid && w < 20) begin step; w++; end
      total++;
      if (!bus.cmd_valid || cmd_q.size() == 0) begin
         bad++;
         $display("FAIL drain: valid=%b queued=%0d want valid=1 with a queued word", bus.cmd_valid, cmd_q.size());
      end else begin
         c = cmd_q.pop_front();
         if (bus.cmd_data !== c.d || bus.cmd_chan !== c.c) begin
            bad++;
            $display("FAIL cmd word: got %h/ch%b want %h/ch%b", bus.cmd_data, bus.cmd_chan, c.d, c.c);
         end
      end
      bus.cmd_ready = 1;
      step;
      bus.cmd_ready = 0;
      #1;
      total++;
      if (bus.cmd_valid !== 1'b0) begin
         bad++;
         $display("FAIL cmd clear: got valid=%b want 0", bus.cmd_valid);
      end
   endtask
   task automatic test_reset;
      bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_data = '0;
      #12;
      total++;
      if ({jtdo1, jtdo2, bus.cmd_valid, bus.cmd_chan, bus.cmd_data, bus.ovr_err, bus.len_err} !== '0) begin
         bad++;
         $display("FAIL reset outputs: got tdo=%b%b v=%b c=%b d=%h o=%b l=%b want all 0", jtdo1, jtdo2,
                  bus.cmd_valid, bus.cmd_chan, bus.cmd_data, bus.ovr_err, bus.len_err);
      end
      @(negedge jtck);
      jrstn = 1;
      step;
   endtask
   task automatic test_basic;
      load_rsp(8'hA5);
      cmd_q.push_back('{8'h3C, 1'b0});
      scan(0, 8'h3C, 8, 8'hA5, 1, -1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== 8'h3C) begin
            bad++;
            $display("FAIL hold %0d: got v=%b d=%h want v=1 d=3c", k, bus.cmd_valid, bus.cmd_data);
         end
         step;
      end
      drain;
   endtask
   task automatic test_len;
      scan(0, 8'h55, 7, 0, 0, -1, 0, 0);
      total++;
      if (bus.len_err !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.ovr_err !== 1'b0) begin
         bad++;
         $display("FAIL len: got l=%b v=%b o=%b want l=1 v=0 o=0", bus.len_err, bus.cmd_valid, bus.ovr_err);
      end
   endtask
   task automatic test_overrun;
      jrstn = 0;
      #2;
      jrstn = 1;
      step;
      cmd_q.push_back('{8'h11, 1'b0});
      scan(0, 8'h11, 8, 0, 0, -1, 0, 0);
      scan(0, 8'h22, 8, 0, 0, -1, 0, 0);
      total++;
      if (bus.cmd_data !== 8'h11 || bus.ovr_err !== 1'b1 || bus.cmd_valid !== 1'b1 || bus.len_err !== 1'b0) begin
         bad++;
         $display("FAIL overrun: got d=%h o=%b v=%b l=%b want d=11 o=1 v=1 l=0",
                  bus.cmd_data, bus.ovr_err, bus.cmd_valid, bus.len_err);
      end
   endtask
   task automatic test_er2;
`ifdef JTAG_ER2_STATUS_EN
      scan(1, 8'h01, 8, 8'h05, 1, -1, 0, 0);
      total++;
      if (bus.ovr_err !== 1'b0 || bus.len_err !== 1'b0 || bus.cmd_data !== 8'h11 || bus.cmd_chan !== 1'b0) begin
         bad++;
         $display("FAIL er2 status: got o=%b l=%b d=%h c=%b want o=0 l=0 d=11 c=0",
                  bus.ovr_err, bus.len_err, bus.cmd_data, bus.cmd_chan);
      end
      drain;
`else
      drain;
      load_rsp(8'hC3);
      cmd_q.push_back('{8'h99, 1'b1});
      scan(1, 8'h99, 8, 8'hC3, 1, -1, 0, 0);
      drain;
`endif
   endtask
   task automatic test_rsp_race;
      load_rsp(8'h10);
      cmd_q.push_back('{8'h01, 1'b0});
      scan(0, 8'h01, 8, 8'h10, 1, -1, 1, 8'h77);
      drain;
      cmd_q.push_back('{8'h02, 1'b0});
      scan(0, 8'h02, 8, 8'h77, 1, -1, 0, 0);
      drain;
   endtask
   task automatic test_reset_mid;
      scan(0, 8'h66, 8, 0, 0, -1, 0, 0);
      scan(0, 8'h5A, 8, 0, 0, 3, 0, 0);
      cmd_q.push_back('{8'h5A, 1'b0});
      scan(0, 8'h5A, 8, 8'h00, 1, -1, 0, 0);
      drain;
   endtask
   task automatic test_back_to_back;
      logic [7:0] v, r;
      for (int k = 0; k < 3; k++) begin
         v = 8'($urandom);
         r = 8'($urandom);
         load_rsp(r);
         cmd_q.push_back('{v, 1'b0});
         scan(0, v, 8, r, 1, -1, 0, 0);
         drain;
      end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_len;
      test_overrun;
      test_er2;
      test_rsp_race;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jtag_er_ctrl.md
JTAG_ER_CTRL -- requirements
Module: jtag_er_ctrl

Interface
REQ-001 SHALL have parameter DR_W, default 8: user DR length in bits, legal range 2..32.
REQ-002 SHALL have port jtck, input, 1 bit: JTAGG JTCK, the only clock; all logic is posedge jtck.
REQ-003 SHALL have port jrstn, input, 1 bit: reset jrstn, asynchronous, active-low.
REQ-004 SHALL have ports jtdi, jshift, jupdate, jce1, jce2, each input, 1 bit: the JTAGG primitive outputs of the same names.
REQ-005 SHALL have ports jtdo1 and jtdo2, each output, 1 bit: TDO returned to JTAGG for ER1 and ER2 respectively.
REQ-006 SHALL have port cmd_data, output, DR_W bits: last updated DR word.
REQ-007 SHALL have ports cmd_valid (output, 1 bit), cmd_ready (input, 1 bit) and cmd_chan (output, 1 bit: 0=ER1, 1=ER2).
REQ-008 SHALL have ports rsp_data (input, DR_W bits) and rsp_valid (input, 1 bit): fabric response word, loaded into rsp_reg.
REQ-009 SHALL have ports ovr_err and len_err, each output, 1 bit: sticky error flags.

Function
REQ-010 SHALL implement FSM states IDLE, CAPT, SHIFT, EXIT.
REQ-011 IDLE or EXIT, jce1 or jce2 high -> CAPT; sr <= capture source; act_chan latched; bit_cnt <= 0; jce1 wins when both are high.
REQ-012 CAPT or EXIT, jshift rising (jshift && !jshift_dly) -> SHIFT; no shift that cycle, since JTDI lags JSHIFT by one cycle; active jtdo = sr[0].
REQ-013 SHIFT, jshift high after the first cycle: sr <= {jtdi, sr[DR_W-1:1]}; active jtdo = sr[1] combinationally; bit_cnt += 1, saturating at DR_W+1.
REQ-014 SHIFT, jshift falling: the last jtdi bit is shifted in that cycle with the same update rule; -> EXIT.
REQ-015 The inactive channel's jtdo, and both jtdo outputs outside SHIFT, SHALL be 0.
REQ-016 EXIT, jupdate high: if bit_cnt == DR_W and cmd_valid == 0, then cmd_data <= sr, cmd_chan <= act_chan, cmd_valid <= 1. If bit_cnt != DR_W, set len_err and drop the word. If cmd_valid == 1, set ovr_err and drop the word; cmd_data is unchanged. In all cases -> IDLE.
REQ-017 jupdate in IDLE, CAPT or SHIFT SHALL be ignored.
REQ-018 cmd_valid SHALL hold with cmd_data stable until cmd_valid && cmd_ready, then clear the next cycle.
REQ-019 An update and an accept in the same cycle SHALL be treated as cmd_valid == 1 (overrun).
REQ-020 rsp_valid SHALL load rsp_reg <= rsp_data every cycle it is high.
REQ-021 A rsp_valid and a capture in the same cycle SHALL capture the old rsp_reg.
REQ-022 ER1 capture source SHALL be rsp_reg.

Reset
REQ-023 jrstn low SHALL asynchronously force state IDLE, and sr, rsp_reg, cmd_data, cmd_valid, cmd_chan, act_chan, bit_cnt, jshift_dly, ovr_err and len_err all to 0.
REQ-024 Reset mid-SHIFT SHALL discard the partial word with no cmd_valid; jtdo1 and jtdo2 read 0 during reset.

Configuration
REQ-025 Macro JTAG_ER2_STATUS_EN: when defined, ER2 is a status channel.
REQ-026 When JTAG_ER2_STATUS_EN is defined, ER2 captures {0..., ovr_err, len_err, cmd_valid} in bits [2:0].
REQ-027 When JTAG_ER2_STATUS_EN is defined, an ER2 update with a legal length and sr[0]=1 clears ovr_err and len_err, never asserts cmd_valid, and never sets ovr_err.
REQ-028 When JTAG_ER2_STATUS_EN is not defined, ER2 behaves identically to ER1, with cmd_chan=1 and capture source rsp_reg.

Verification
REQ-029 DR_W=8, rsp 0xA5, ER1 capture then 8-bit shift of 0x3C then update -> TDO bits LSB-first 1,0,1,0,0,1,0,1; cmd_data=0x3C, cmd_chan=0, cmd_valid=1 until cmd_ready.
REQ-030 ER1 shift of 7 bits, then update -> len_err=1, cmd_valid stays 0.
REQ-031 Two ER1 updates (0x11 then 0x22) with cmd_ready=0 -> cmd_data=0x11, ovr_err=1.
REQ-032 With JTAG_ER2_STATUS_EN: after REQ-031, ER2 capture -> TDO first 3 bits 1,0,1; ER2 update with 0x01 -> both flags 0 and no cmd_valid.
REQ-033 jrstn low during the fourth shift bit -> all outputs 0 immediately; a following full ER1 transaction of 0x5A -> cmd_data=0x5A.
REQ-034 rsp_valid with 0x77 in the capture cycle while rsp_reg=0x10 -> captures 0x10; the next capture yields 0x77.
